// File: rtl/issue_pair_splitter.sv
// Dual-issue pairing stage: splits conflicting decode pairs, replaying slot 1 as slot 0 next issue cycle.
// Optional perf counter output split_cnt is enabled by defining ISSUE_SPLIT_PERF_EN.
module issue_pair_splitter #(
  parameter int                      DATA_WIDTH   = 32,
  parameter int                      ALU_OP_WIDTH = 5,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_MUL      = 5'd16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid_0,
  input  logic                    id_valid_1,
  input  logic [ALU_OP_WIDTH-1:0] id_AluOp_0,
  input  logic [ALU_OP_WIDTH-1:0] id_AluOp_1,
  input  logic [DATA_WIDTH-1:0]   id_pc_0,
  input  logic [DATA_WIDTH-1:0]   id_pc_1,
  input  logic [DATA_WIDTH-1:0]   id_inst_0,
  input  logic [DATA_WIDTH-1:0]   id_inst_1,
  input  logic                    id_LdStFlag_0,
  input  logic                    id_BranchFlag_0,
  input  logic                    ex_stall,
  input  logic                    flush,
  output logic                    id_ready,
  output logic                    is_valid_0,
  output logic                    is_valid_1,
  output logic [ALU_OP_WIDTH-1:0] is_AluOp_0,
  output logic [ALU_OP_WIDTH-1:0] is_AluOp_1,
  output logic [DATA_WIDTH-1:0]   is_pc_0,
  output logic [DATA_WIDTH-1:0]   is_pc_1,
  output logic [DATA_WIDTH-1:0]   is_inst_0,
  output logic [DATA_WIDTH-1:0]   is_inst_1
`ifdef ISSUE_SPLIT_PERF_EN
  ,
  output logic [31:0]             split_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_PASS   = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ALU_OP_WIDTH-1:0] buf_op_r;
  logic [DATA_WIDTH-1:0]   buf_pc_r;
  logic [DATA_WIDTH-1:0]   buf_inst_r;
  logic [ALU_OP_WIDTH-1:0] buf_op_nxt_s;
  logic [DATA_WIDTH-1:0]   buf_pc_nxt_s;
  logic [DATA_WIDTH-1:0]   buf_inst_nxt_s;

  logic                    v0_nxt_s;
  logic                    v1_nxt_s;
  logic [ALU_OP_WIDTH-1:0] op0_nxt_s;
  logic [ALU_OP_WIDTH-1:0] op1_nxt_s;
  logic [DATA_WIDTH-1:0]   pc0_nxt_s;
  logic [DATA_WIDTH-1:0]   pc1_nxt_s;
  logic [DATA_WIDTH-1:0]   inst0_nxt_s;
  logic [DATA_WIDTH-1:0]   inst1_nxt_s;

  logic                    conflict_s;
  logic                    enter_replay_s;

  // Slot 1 cannot share an issue cycle with a mem/branch slot 0 or a second mul/div op.
  always_comb begin
    conflict_s = id_valid_0 & id_valid_1 &
                 (id_LdStFlag_0 | id_BranchFlag_0 |
                  ((id_AluOp_0 >= ALU_MUL) & (id_AluOp_1 >= ALU_MUL)));
  end

  // Decode handshake: only an unstalled, unflushed PASS cycle accepts a pair.
  always_comb begin
    if (!rst && !flush && !ex_stall && (state_r == ST_PASS)) begin
      id_ready = 1'b1;
    end else begin
      id_ready = 1'b0;
    end
    enter_replay_s = id_ready & conflict_s;
  end

  // Next-state and next-issue selection; defaults hold every register.
  always_comb begin
    state_nxt_s    = state_r;
    buf_op_nxt_s   = buf_op_r;
    buf_pc_nxt_s   = buf_pc_r;
    buf_inst_nxt_s = buf_inst_r;
    v0_nxt_s       = is_valid_0;
    v1_nxt_s       = is_valid_1;
    op0_nxt_s      = is_AluOp_0;
    op1_nxt_s      = is_AluOp_1;
    pc0_nxt_s      = is_pc_0;
    pc1_nxt_s      = is_pc_1;
    inst0_nxt_s    = is_inst_0;
    inst1_nxt_s    = is_inst_1;
    if (flush) begin
      state_nxt_s    = ST_PASS;
      buf_op_nxt_s   = {ALU_OP_WIDTH{1'b0}};
      buf_pc_nxt_s   = {DATA_WIDTH{1'b0}};
      buf_inst_nxt_s = {DATA_WIDTH{1'b0}};
      v0_nxt_s       = 1'b0;
      v1_nxt_s       = 1'b0;
      op0_nxt_s      = {ALU_OP_WIDTH{1'b0}};
      op1_nxt_s      = {ALU_OP_WIDTH{1'b0}};
      pc0_nxt_s      = {DATA_WIDTH{1'b0}};
      pc1_nxt_s      = {DATA_WIDTH{1'b0}};
      inst0_nxt_s    = {DATA_WIDTH{1'b0}};
      inst1_nxt_s    = {DATA_WIDTH{1'b0}};
    end else if (ex_stall) begin
      state_nxt_s = state_r;
    end else begin
      // Slot 1 is zeroed in every path below unless a real pair issues together.
      v1_nxt_s    = 1'b0;
      op1_nxt_s   = {ALU_OP_WIDTH{1'b0}};
      pc1_nxt_s   = {DATA_WIDTH{1'b0}};
      inst1_nxt_s = {DATA_WIDTH{1'b0}};
      case (state_r)
        ST_PASS: begin
          if (conflict_s) begin
            v0_nxt_s       = 1'b1;
            op0_nxt_s      = id_AluOp_0;
            pc0_nxt_s      = id_pc_0;
            inst0_nxt_s    = id_inst_0;
            buf_op_nxt_s   = id_AluOp_1;
            buf_pc_nxt_s   = id_pc_1;
            buf_inst_nxt_s = id_inst_1;
            state_nxt_s    = ST_REPLAY;
          end else if (id_valid_0) begin
            v0_nxt_s    = 1'b1;
            op0_nxt_s   = id_AluOp_0;
            pc0_nxt_s   = id_pc_0;
            inst0_nxt_s = id_inst_0;
            if (id_valid_1) begin
              v1_nxt_s    = 1'b1;
              op1_nxt_s   = id_AluOp_1;
              pc1_nxt_s   = id_pc_1;
              inst1_nxt_s = id_inst_1;
            end else begin
              v1_nxt_s = 1'b0;
            end
          end else if (id_valid_1) begin
            v0_nxt_s    = 1'b1;
            op0_nxt_s   = id_AluOp_1;
            pc0_nxt_s   = id_pc_1;
            inst0_nxt_s = id_inst_1;
          end else begin
            v0_nxt_s    = 1'b0;
            op0_nxt_s   = {ALU_OP_WIDTH{1'b0}};
            pc0_nxt_s   = {DATA_WIDTH{1'b0}};
            inst0_nxt_s = {DATA_WIDTH{1'b0}};
          end
        end
        ST_REPLAY: begin
          v0_nxt_s       = 1'b1;
          op0_nxt_s      = buf_op_r;
          pc0_nxt_s      = buf_pc_r;
          inst0_nxt_s    = buf_inst_r;
          buf_op_nxt_s   = {ALU_OP_WIDTH{1'b0}};
          buf_pc_nxt_s   = {DATA_WIDTH{1'b0}};
          buf_inst_nxt_s = {DATA_WIDTH{1'b0}};
          state_nxt_s    = ST_PASS;
        end
        default: begin
          state_nxt_s = ST_PASS;
          v0_nxt_s    = 1'b0;
          op0_nxt_s   = {ALU_OP_WIDTH{1'b0}};
          pc0_nxt_s   = {DATA_WIDTH{1'b0}};
          inst0_nxt_s = {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Issue registers, replay buffer and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_PASS;
      buf_op_r   <= {ALU_OP_WIDTH{1'b0}};
      buf_pc_r   <= {DATA_WIDTH{1'b0}};
      buf_inst_r <= {DATA_WIDTH{1'b0}};
      is_valid_0 <= 1'b0;
      is_valid_1 <= 1'b0;
      is_AluOp_0 <= {ALU_OP_WIDTH{1'b0}};
      is_AluOp_1 <= {ALU_OP_WIDTH{1'b0}};
      is_pc_0    <= {DATA_WIDTH{1'b0}};
      is_pc_1    <= {DATA_WIDTH{1'b0}};
      is_inst_0  <= {DATA_WIDTH{1'b0}};
      is_inst_1  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      buf_op_r   <= buf_op_nxt_s;
      buf_pc_r   <= buf_pc_nxt_s;
      buf_inst_r <= buf_inst_nxt_s;
      is_valid_0 <= v0_nxt_s;
      is_valid_1 <= v1_nxt_s;
      is_AluOp_0 <= op0_nxt_s;
      is_AluOp_1 <= op1_nxt_s;
      is_pc_0    <= pc0_nxt_s;
      is_pc_1    <= pc1_nxt_s;
      is_inst_0  <= inst0_nxt_s;
      is_inst_1  <= inst1_nxt_s;
    end
  end

`ifdef ISSUE_SPLIT_PERF_EN
  logic [31:0] split_cnt_r;

  assign split_cnt = split_cnt_r;

  // Saturating count of split pairs; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      split_cnt_r <= 32'd0;
    end else if (enter_replay_s && (split_cnt_r != 32'hFFFF_FFFF)) begin
      split_cnt_r <= split_cnt_r + 32'd1;
    end else begin
      split_cnt_r <= split_cnt_r;
    end
  end
`else
  logic unused_s;

  assign unused_s = enter_replay_s;
`endif

endmodule

// File: tb/tb_issue_pair_splitter.sv
// Randomized scoreboard bench for issue_pair_splitter against a queue-based instruction-stream model.
module tb_issue_pair_splitter;
  localparam int         DW    = 32;
  localparam int         AW    = 5;
  localparam logic [4:0] MULOP = 5'd16;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] op;
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
  } slot_t;

  typedef struct {
    int          due;
    bit          kind;
    logic        ready;
    slot_t       s0;
    slot_t       s1;
    logic [31:0] cnt;
  } chk_t;

  logic clk = 1'b0;
  logic rst, flush, ex_stall;
  logic id_valid_0, id_valid_1, id_LdStFlag_0, id_BranchFlag_0;
  logic [AW-1:0] id_AluOp_0, id_AluOp_1;
  logic [DW-1:0] id_pc_0, id_pc_1, id_inst_0, id_inst_1;
  logic id_ready, is_valid_0, is_valid_1;
  logic [AW-1:0] is_AluOp_0, is_AluOp_1;
  logic [DW-1:0] is_pc_0, is_pc_1, is_inst_0, is_inst_1;
`ifdef ISSUE_SPLIT_PERF_EN
  logic [31:0] split_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  chk_t sb[$];

  slot_t       m_s0, m_s1;
  slot_t       m_q[$];
  logic [31:0] m_cnt;

  issue_pair_splitter dut (
    .clk(clk), .rst(rst),
    .id_valid_0(id_valid_0), .id_valid_1(id_valid_1),
    .id_AluOp_0(id_AluOp_0), .id_AluOp_1(id_AluOp_1),
    .id_pc_0(id_pc_0), .id_pc_1(id_pc_1),
    .id_inst_0(id_inst_0), .id_inst_1(id_inst_1),
    .id_LdStFlag_0(id_LdStFlag_0), .id_BranchFlag_0(id_BranchFlag_0),
    .ex_stall(ex_stall), .flush(flush), .id_ready(id_ready),
    .is_valid_0(is_valid_0), .is_valid_1(is_valid_1),
    .is_AluOp_0(is_AluOp_0), .is_AluOp_1(is_AluOp_1),
    .is_pc_0(is_pc_0), .is_pc_1(is_pc_1),
    .is_inst_0(is_inst_0), .is_inst_1(is_inst_1)
`ifdef ISSUE_SPLIT_PERF_EN
    , .split_cnt(split_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Apply the current inputs to the model for one clock and schedule the checks.
  task automatic apply();
    logic  exp_ready;
    slot_t lst[$];
    slot_t a;
    chk_t  c;
    exp_ready = 1'b0;
    if (rst) begin
      m_s0 = '0; m_s1 = '0; m_q.delete(); m_cnt = 32'd0;
    end else if (flush) begin
      m_s0 = '0; m_s1 = '0; m_q.delete();
    end else if (ex_stall) begin
      exp_ready = 1'b0;
    end else if (m_q.size() > 0) begin
      m_s0 = m_q.pop_front(); m_s1 = '0;
    end else begin
      exp_ready = 1'b1;
      if (id_valid_0) begin a = {1'b1, id_AluOp_0, id_pc_0, id_inst_0}; lst.push_back(a); end
      if (id_valid_1) begin a = {1'b1, id_AluOp_1, id_pc_1, id_inst_1}; lst.push_back(a); end
      if (id_valid_0 && id_valid_1 &&
          (id_LdStFlag_0 || id_BranchFlag_0 || (id_AluOp_0 >= MULOP && id_AluOp_1 >= MULOP))) begin
        m_s0 = lst[0]; m_s1 = '0; m_q.push_back(lst[1]);
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        m_s0 = (lst.size() > 0) ? lst[0] : '0;
        m_s1 = (lst.size() > 1) ? lst[1] : '0;
      end
    end
    c.due = cyc; c.kind = 1'b0; c.ready = exp_ready; c.s0 = '0; c.s1 = '0; c.cnt = 32'd0;
    sb.push_back(c);
    c.due = cyc + 1; c.kind = 1'b1; c.s0 = m_s0; c.s1 = m_s1; c.cnt = m_cnt;
    sb.push_back(c);
    @(posedge clk); #1;
  endtask

  task automatic drv(input bit r, input bit f, input bit st, input bit v0, input bit v1,
                     input logic [4:0] op0, input logic [4:0] op1,
                     input logic [31:0] pc0, input logic [31:0] pc1, input bit ls, input bit br);
    rst = r; flush = f; ex_stall = st; id_valid_0 = v0; id_valid_1 = v1;
    id_AluOp_0 = op0; id_AluOp_1 = op1; id_pc_0 = pc0; id_pc_1 = pc1;
    id_inst_0 = $urandom; id_inst_1 = $urandom; id_LdStFlag_0 = ls; id_BranchFlag_0 = br;
    apply();
  endtask

  // Monitor: pop every check that is due this cycle and compare against the DUT.
  always @(negedge clk) begin
    chk_t  c;
    slot_t a0, a1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      c = sb.pop_front();
      vectors++;
      if (c.kind == 1'b0) begin
        if (id_ready !== c.ready) begin
          miscompares++;
          $display("FAIL id_ready cyc=%0d got=%b exp=%b", cyc, id_ready, c.ready);
        end
      end else begin
        a0 = {is_valid_0, is_AluOp_0, is_pc_0, is_inst_0};
        a1 = {is_valid_1, is_AluOp_1, is_pc_1, is_inst_1};
        if (a0 !== c.s0 || a1 !== c.s1) begin
          miscompares++;
          $display("FAIL issue cyc=%0d got s0=%h s1=%h exp s0=%h s1=%h", cyc, a0, a1, c.s0, c.s1);
        end
`ifdef ISSUE_SPLIT_PERF_EN
        vectors++;
        if (split_cnt !== c.cnt) begin
          miscompares++;
          $display("FAIL split_cnt cyc=%0d got=%0d exp=%0d", cyc, split_cnt, c.cnt);
        end
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; id_valid_0 = 1'b0; id_valid_1 = 1'b0;
    id_AluOp_0 = 5'd0; id_AluOp_1 = 5'd0; id_pc_0 = 32'd0; id_pc_1 = 32'd0;
    id_inst_0 = 32'd0; id_inst_1 = 32'd0; id_LdStFlag_0 = 1'b0; id_BranchFlag_0 = 1'b0;
    m_s0 = '0; m_s1 = '0; m_cnt = 32'd0;
    @(posedge clk); #1;
    // Reset held with valid decode
    drv(1, 0, 0, 1, 1, 5'd1, 5'd2, 32'h10, 32'h14, 0, 0);
    drv(1, 0, 0, 1, 1, 5'd1, 5'd2, 32'h10, 32'h14, 0, 0);
    // Dual ALU pair
    drv(0, 0, 0, 1, 1, 5'd1, 5'd2, 32'h100, 32'h104, 0, 0);
    // Load/store split, next pair offered during replay then re-offered
    drv(0, 0, 0, 1, 1, 5'd3, 5'd4, 32'h200, 32'h204, 1, 0);
    drv(0, 0, 0, 1, 1, 5'd1, 5'd1, 32'h208, 32'h20C, 0, 0);
    drv(0, 0, 0, 1, 1, 5'd1, 5'd1, 32'h208, 32'h20C, 0, 0);
    // Mul+mul split with 3-cycle stall during replay
    drv(0, 0, 0, 1, 1, 5'd16, 5'd17, 32'h500, 32'h504, 0, 0);
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 1, 1, 5'd1, 5'd2, 32'h600, 32'h604, 0, 0);
    drv(0, 0, 0, 1, 1, 5'd1, 5'd2, 32'h600, 32'h604, 0, 0);
    drv(0, 0, 0, 1, 1, 5'd1, 5'd2, 32'h600, 32'h604, 0, 0);
    // Branch split then flush during replay
    drv(0, 0, 0, 1, 1, 5'd5, 5'd6, 32'h300, 32'h304, 0, 1);
    drv(0, 1, 0, 1, 1, 5'd1, 5'd2, 32'h700, 32'h704, 0, 0);
    drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0);
    // Compaction and mul/div boundary
    drv(0, 0, 0, 0, 1, 5'd7, 5'd9, 32'h400, 32'h404, 0, 0);
    drv(0, 0, 0, 1, 1, 5'd16, 5'd15, 32'h800, 32'h804, 0, 0);
    drv(0, 0, 0, 1, 1, 5'd15, 5'd31, 32'h810, 32'h814, 0, 0);
    drv(0, 0, 0, 1, 1, 5'd31, 5'd16, 32'h820, 32'h824, 0, 0);
    drv(0, 0, 0, 1, 1, 5'd1, 5'd1, 32'h830, 32'h834, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      drv(($urandom_range(99) < 1), ($urandom_range(99) < 5), ($urandom_range(99) < 20),
          ($urandom_range(99) < 75), ($urandom_range(99) < 75),
          5'($urandom), 5'($urandom), $urandom, $urandom,
          ($urandom_range(99) < 20), ($urandom_range(99) < 15));
    end
    rst = 1'b0; flush = 1'b0; ex_stall = 1'b0; id_valid_0 = 1'b0; id_valid_1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d checks left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
